// File: rtl/wvb_stream_reader_if.sv
// Waveform-buffer and readout-stream signals for wvb_stream_reader.
// The master side is the reader; the slave side is the buffer plus the downstream sink.
interface wvb_stream_reader_if #(
    parameter int P_DATA_WIDTH = 22,
    parameter int P_HDR_WIDTH  = 80
);
    logic                    wvb_hdr_empty;
    logic [P_HDR_WIDTH-1:0]  wvb_hdr_data_out;
    logic                    wvb_hdr_rdreq;
    logic [P_DATA_WIDTH-1:0] wvb_data_out;
    logic                    wvb_wvb_rdreq;
    logic                    wvb_wvb_rddone;
    logic [31:0]             dout;
    logic                    dout_valid;
    logic                    dout_ready;
    logic                    dout_last;

    modport master (
        input  wvb_hdr_empty, wvb_hdr_data_out, wvb_data_out, dout_ready,
        output wvb_hdr_rdreq, wvb_wvb_rdreq, wvb_wvb_rddone, dout, dout_valid, dout_last
    );

    modport slave (
        output wvb_hdr_empty, wvb_hdr_data_out, wvb_data_out, dout_ready,
        input  wvb_hdr_rdreq, wvb_wvb_rdreq, wvb_wvb_rddone, dout, dout_valid, dout_last
    );
endinterface

// File: rtl/wvb_stream_reader.sv
// Drains the waveform buffer: pops a header and its samples, then emits one framed
// 32-bit word stream per waveform through a 2-entry valid/ready output FIFO.
module wvb_stream_reader #(
    parameter int P_DATA_WIDTH  = 22,
    parameter int P_HDR_WIDTH   = 80,
    parameter int P_MAX_SAMPLES = 4096,
    parameter int P_CNT_WIDTH   = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    wvb_stream_reader_if.master    bus,
    output logic                   busy,
    output logic [P_CNT_WIDTH-1:0] n_wvf_read,
    output logic                   trunc_err
);
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_HDR  = 3'd1;
    localparam logic [2:0] S_H0   = 3'd2;
    localparam logic [2:0] S_H1   = 3'd3;
    localparam logic [2:0] S_H2   = 3'd4;
    localparam logic [2:0] S_DATA = 3'd5;
    localparam logic [2:0] S_DONE = 3'd6;

    localparam int               SCNT_W    = $clog2(P_MAX_SAMPLES) + 1;
    localparam logic [SCNT_W-1:0] SCNT_LAST = SCNT_W'(P_MAX_SAMPLES - 1);

    logic [2:0]             state_q, state_d;
    logic [P_HDR_WIDTH-1:0] hdr_q, hdr_d;
    logic                   hdr_rdreq_q, hdr_rdreq_d;
    logic                   rd_pend_q, rd_pend_d;
    logic [SCNT_W-1:0]      scnt_q, scnt_d;
    logic                   busy_q, busy_d;
    logic [P_CNT_WIDTH-1:0] n_wvf_q, n_wvf_d;
    logic                   trunc_q, trunc_d;
    logic [1:0][32:0]       fifo_q, fifo_d;
    logic                   wr_ptr_q, wr_ptr_d;
    logic                   rd_ptr_q, rd_ptr_d;
    logic [1:0]             fcnt_q, fcnt_d;

    logic        push;
    logic        push_last;
    logic [31:0] push_word;
    logic        pop;
    logic        fifo_full;
    logic        rdreq;
    logic        eoe;
    logic        term;
    logic        room;
    logic [32:0] head;

    assign head      = fifo_q[rd_ptr_q];
    assign pop       = (fcnt_q != 2'd0) && bus.dout_ready;
    assign fifo_full = (fcnt_q == 2'd2);
    assign eoe       = bus.wvb_data_out[P_DATA_WIDTH-1];
    assign term      = rd_pend_q && (eoe || (scnt_q == SCNT_LAST));
    // A new read is allowed only if a slot is guaranteed when its sample returns,
    // counting the sample already on the bus this cycle.
    assign room      = ({1'b0, fcnt_q} + {2'b00, rd_pend_q}) <= (3'd1 + {2'b00, pop});

    always_comb begin
        state_d     = state_q;
        hdr_d       = hdr_q;
        hdr_rdreq_d = 1'b0;
        rd_pend_d   = 1'b0;
        scnt_d      = scnt_q;
        busy_d      = busy_q;
        n_wvf_d     = n_wvf_q;
        trunc_d     = trunc_q;
        push        = 1'b0;
        push_last   = 1'b0;
        push_word   = 32'h0;
        rdreq       = 1'b0;

        if (pop && head[32]) begin
            busy_d = 1'b0;
        end

        unique case (state_q)
            S_IDLE: begin
                if (en && !bus.wvb_hdr_empty) begin
                    hdr_d       = bus.wvb_hdr_data_out;
                    hdr_rdreq_d = 1'b1;
                    busy_d      = 1'b1;
                    state_d     = S_HDR;
                end
            end
            S_HDR: begin
                scnt_d  = '0;
                state_d = S_H0;
            end
            S_H0: begin
                if (!fifo_full) begin
                    push      = 1'b1;
                    push_word = {8'hA5, 8'h00, hdr_q[79:64]};
                    state_d   = S_H1;
                end
            end
            S_H1: begin
                if (!fifo_full) begin
                    push      = 1'b1;
                    push_word = hdr_q[63:32];
                    state_d   = S_H2;
                end
            end
            S_H2: begin
                if (!fifo_full) begin
                    push      = 1'b1;
                    push_word = hdr_q[31:0];
                    state_d   = S_DATA;
                end
            end
            S_DATA: begin
                if (rd_pend_q) begin
                    push      = 1'b1;
                    push_word = {{(32-P_DATA_WIDTH){1'b0}}, bus.wvb_data_out};
                    push_last = term;
                    scnt_d    = scnt_q + SCNT_W'(1);
                    if (term) begin
                        state_d = S_DONE;
                        if (!eoe) begin
                            trunc_d = 1'b1;
                        end
                    end
                end
                rdreq     = !term && room;
                rd_pend_d = rdreq;
            end
            S_DONE: begin
                n_wvf_d = n_wvf_q + {{(P_CNT_WIDTH-1){1'b0}}, 1'b1};
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        fifo_d   = fifo_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            fifo_d[wr_ptr_q] = {push_last, push_word};
            wr_ptr_d         = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        fcnt_d = fcnt_q + {1'b0, push} - {1'b0, pop};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            hdr_q       <= '0;
            hdr_rdreq_q <= 1'b0;
            rd_pend_q   <= 1'b0;
            scnt_q      <= '0;
            busy_q      <= 1'b0;
            n_wvf_q     <= '0;
            trunc_q     <= 1'b0;
            fifo_q      <= '0;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            fcnt_q      <= 2'd0;
        end else begin
            state_q     <= state_d;
            hdr_q       <= hdr_d;
            hdr_rdreq_q <= hdr_rdreq_d;
            rd_pend_q   <= rd_pend_d;
            scnt_q      <= scnt_d;
            busy_q      <= busy_d;
            n_wvf_q     <= n_wvf_d;
            trunc_q     <= trunc_d;
            fifo_q      <= fifo_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            fcnt_q      <= fcnt_d;
        end
    end

    assign bus.dout           = head[31:0];
    assign bus.dout_valid     = (fcnt_q != 2'd0);
    assign bus.dout_last      = head[32] && (fcnt_q != 2'd0);
    assign bus.wvb_hdr_rdreq  = hdr_rdreq_q;
    assign bus.wvb_wvb_rdreq  = rdreq;
    assign bus.wvb_wvb_rddone = (state_q == S_DONE);
    assign busy               = busy_q;
    assign n_wvf_read         = n_wvf_q;
    assign trunc_err          = trunc_q;
endmodule

// File: tb/tb_wvb_stream_reader.sv
// Scoreboard bench for wvb_stream_reader: models the header/sample buffer and the sink,
// queues expected stream words at stimulus time and checks them as the DUT emits them.
module tb_wvb_stream_reader;
    localparam int MAX_SMP = 4096;
    localparam int CNT_W   = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             en  = 1'b0;
    logic             busy;
    logic [CNT_W-1:0] n_wvf_read;
    logic             trunc_err;

    wvb_stream_reader_if bus_if ();

    // Narrow completion counter so its wrap is reachable in a short run.
    wvb_stream_reader #(.P_CNT_WIDTH(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .bus        (bus_if.master),
        .busy       (busy),
        .n_wvf_read (n_wvf_read),
        .trunc_err  (trunc_err)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          rddone_cnt = 0;
    int          hdr_pops = 0;
    int          taken = 0;
    int          cyc = 0;
    int          ready_mode = 0;
    logic [79:0] hdr_q[$];
    logic [21:0] smp_q[$];
    int          len_q[$];
    logic [32:0] exp_q[$];
    int          xfer_cyc_q[$];

    task automatic checkOutput(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("[TB] FAIL %s: got %0h, expected %0h", tag, act, exp);
    endtask

    task automatic applyStimulus(input logic [79:0] hdr, input int n, input bit with_eoe);
        logic [21:0] s;
        bit          last;
        hdr_q.push_back(hdr);
        len_q.push_back(n);
        exp_q.push_back({1'b0, 8'hA5, 8'h00, hdr[79:64]});
        exp_q.push_back({1'b0, hdr[63:32]});
        exp_q.push_back({1'b0, hdr[31:0]});
        for (int i = 0; i < n; i++) begin
            s[20:0] = 21'($urandom);
            s[21]   = with_eoe && (i == n - 1);
            smp_q.push_back(s);
            if (i < MAX_SMP) begin
                last = s[21] || (i == MAX_SMP - 1);
                exp_q.push_back({last, 10'b0, s});
            end
        end
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_ctrl"}, 64'({bus_if.dout_valid, bus_if.dout_last, bus_if.wvb_hdr_rdreq,
                    bus_if.wvb_wvb_rdreq, bus_if.wvb_wvb_rddone, busy, trunc_err}), 64'(0));
        checkOutput({tag, "_dout"}, 64'(bus_if.dout), 64'(0));
        checkOutput({tag, "_nwvf"}, 64'(n_wvf_read), 64'(0));
    endtask

    task automatic waitRddone(input int target, input int budget, input string tag);
        int i = 0;
        while (rddone_cnt < target && i < budget) begin
            @(posedge clk); #3; i++;
        end
        checkOutput(tag, 64'(rddone_cnt), 64'(target));
    endtask

    task automatic waitDrain(input int budget, input string tag);
        int i = 0;
        while (exp_q.size() != 0 && i < budget) begin
            @(posedge clk); #3; i++;
        end
        checkOutput(tag, 64'(exp_q.size()), 64'(0));
    endtask

    task automatic waitHdrPops(input int target, input int budget, input string tag);
        int i = 0;
        while (hdr_pops < target && i < budget) begin
            @(posedge clk); #3; i++;
        end
        checkOutput(tag, 64'(hdr_pops), 64'(target));
    endtask

    initial begin
        int base;
        bus_if.wvb_hdr_empty    = 1'b1;
        bus_if.wvb_hdr_data_out = '0;
        bus_if.wvb_data_out     = '0;
        bus_if.dout_ready       = 1'b1;

        fork
            begin : sink_and_buffer
                bit          do_pop, do_rd, do_done, stalled;
                logic [32:0] held, e;
                stalled = 1'b0;
                held    = '0;
                forever begin
                    @(negedge clk);
                    case (ready_mode)
                        0:       bus_if.dout_ready = 1'b1;
                        1:       bus_if.dout_ready = ~bus_if.dout_ready;
                        default: bus_if.dout_ready = 1'($urandom_range(0, 1));
                    endcase
                    #1;
                    do_pop = 1'b0; do_rd = 1'b0; do_done = 1'b0;
                    if (rst) begin
                        hdr_q.delete(); smp_q.delete(); len_q.delete(); exp_q.delete();
                        taken   = 0;
                        stalled = 1'b0;
                    end else begin
                        checkOutput("rdreq_excl", 64'(bus_if.wvb_hdr_rdreq & bus_if.wvb_wvb_rdreq), 64'(0));
                        if (stalled)
                            checkOutput("stall_hold", 64'({bus_if.dout_valid, bus_if.dout_last, bus_if.dout}),
                                        64'({1'b1, held}));
                        stalled = bus_if.dout_valid && !bus_if.dout_ready;
                        held    = {bus_if.dout_last, bus_if.dout};
                        if (bus_if.dout_valid && bus_if.dout_ready) begin
                            checkOutput("exp_avail", 64'(exp_q.size() != 0), 64'(1));
                            if (exp_q.size() != 0) begin
                                e = exp_q.pop_front();
                                checkOutput("dout_word", 64'({bus_if.dout_last, bus_if.dout}), 64'(e));
                            end
                            xfer_cyc_q.push_back(cyc);
                        end
                        do_pop  = bus_if.wvb_hdr_rdreq;
                        do_rd   = bus_if.wvb_wvb_rdreq;
                        do_done = bus_if.wvb_wvb_rddone;
                    end
                    @(posedge clk); #1;
                    cyc++;
                    if (do_pop) begin
                        hdr_pops++;
                        if (hdr_q.size() != 0) void'(hdr_q.pop_front());
                    end
                    if (do_rd && smp_q.size() != 0) begin
                        bus_if.wvb_data_out = smp_q.pop_front();
                        taken++;
                    end
                    if (do_done) begin
                        rddone_cnt++;
                        if (len_q.size() != 0) begin
                            for (int i = taken; i < len_q[0]; i++)
                                if (smp_q.size() != 0) void'(smp_q.pop_front());
                            void'(len_q.pop_front());
                        end
                        taken = 0;
                    end
                    bus_if.wvb_hdr_empty    = (hdr_q.size() == 0);
                    bus_if.wvb_hdr_data_out = (hdr_q.size() != 0) ? hdr_q[0] : 80'h0;
                end
            end
        join_none

        #2 rst = 1'b1;
        #1 checkResetOutputs("reset");
        @(posedge clk); @(posedge clk); #3;
        rst = 1'b0;

        $display("[TB] single 4-sample frame, sink always ready");
        applyStimulus(80'h1234_89ABCDEF_01234567, 4, 1'b1);
        en = 1'b1;
        waitHdrPops(1, 20, "t1_hdr_pop");
        checkOutput("t1_busy_mid", 64'(busy), 64'(1));
        waitRddone(1, 100, "t1_rddone");
        waitDrain(20, "t1_drain");
        checkOutput("t1_nwvf", 64'(n_wvf_read), 64'(1));
        checkOutput("t1_trunc", 64'(trunc_err), 64'(0));
        checkOutput("t1_busy_end", 64'(busy), 64'(0));

        $display("[TB] same frame with sink ready toggling");
        ready_mode = 1;
        applyStimulus(80'h1234_89ABCDEF_01234567, 4, 1'b1);
        waitRddone(2, 200, "t2_rddone");
        waitDrain(40, "t2_drain");
        checkOutput("t2_nwvf", 64'(n_wvf_read), 64'(2));
        ready_mode = 0;

        $display("[TB] 4100-sample waveform without end marker");
        repeat (3) @(posedge clk);
        #3;
        xfer_cyc_q.delete();
        applyStimulus(80'hBEEF_00000003_CAFEF00D, 4100, 1'b0);
        waitRddone(3, 6000, "t3_rddone");
        waitDrain(20, "t3_drain");
        checkOutput("t3_xfers", 64'(xfer_cyc_q.size()), 64'(3 + MAX_SMP));
        if (xfer_cyc_q.size() == 3 + MAX_SMP)
            checkOutput("t3_throughput", 64'(xfer_cyc_q[2 + MAX_SMP] - xfer_cyc_q[3]), 64'(MAX_SMP - 1));
        checkOutput("t3_trunc", 64'(trunc_err), 64'(1));
        checkOutput("t3_nwvf", 64'(n_wvf_read), 64'(3));
        repeat (5) @(posedge clk);
        #3;
        checkOutput("t3_rddone_once", 64'(rddone_cnt), 64'(3));

        $display("[TB] three queued headers, enable dropped after first pop");
        en = 1'b0;
        applyStimulus(80'h0001_11111111_11111111, 5, 1'b1);
        applyStimulus(80'h0002_22222222_22222222, 5, 1'b1);
        applyStimulus(80'h0003_33333333_33333333, 5, 1'b1);
        base = hdr_pops;
        en = 1'b1;
        waitHdrPops(base + 1, 20, "t4_first_pop");
        en = 1'b0;
        waitRddone(4, 100, "t4_one_frame");
        repeat (20) @(posedge clk);
        #3;
        checkOutput("t4_no_more_pops", 64'(hdr_pops), 64'(base + 1));
        checkOutput("t4_hdrs_left", 64'(hdr_q.size()), 64'(2));
        checkOutput("t4_rddone_held", 64'(rddone_cnt), 64'(4));
        en = 1'b1;
        waitRddone(6, 200, "t4_rest");
        waitDrain(20, "t4_drain");
        checkOutput("t4_nwvf", 64'(n_wvf_read), 64'(6));

        $display("[TB] reset in the middle of a waveform");
        base = xfer_cyc_q.size();
        applyStimulus(80'h0ABC_44444444_55555555, 50, 1'b1);
        for (int i = 0; i < 100 && xfer_cyc_q.size() < base + 8; i++) begin
            @(posedge clk); #3;
        end
        checkOutput("t5_mid_frame", 64'(xfer_cyc_q.size() >= base + 8), 64'(1));
        base = rddone_cnt;
        rst = 1'b1;
        #1 checkResetOutputs("t5_reset");
        repeat (3) @(posedge clk);
        #3;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        checkOutput("t5_no_rddone", 64'(rddone_cnt), 64'(base));
        applyStimulus(80'h0DEF_66666666_77777777, 6, 1'b1);
        waitRddone(base + 1, 100, "t5_clean_rddone");
        waitDrain(20, "t5_clean_drain");
        checkOutput("t5_nwvf", 64'(n_wvf_read), 64'(1));

        $display("[TB] completion counter wrap");
        base = rddone_cnt;
        for (int i = 0; i < 14; i++)
            applyStimulus(80'h5A5A_00000000_00000000 | 80'(i), 1, 1'b1);
        waitRddone(base + 14, 400, "t6_frames");
        waitDrain(20, "t6_drain");
        checkOutput("t6_nwvf_max", 64'(n_wvf_read), 64'((1 << CNT_W) - 1));
        applyStimulus(80'hFFFF_FFFFFFFF_FFFFFFFF, 1, 1'b1);
        waitRddone(base + 15, 40, "t6_wrap_frame");
        waitDrain(20, "t6_wrap_drain");
        checkOutput("t6_nwvf_wrap", 64'(n_wvf_read), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
